gauss_filter_cfg: RTL and testbench
===================================

# gauss_filter_cfg

Configurable 3x3 smoothing filter for the video image-processing chain. It sits directly after the 3x3 matrix generator and before downstream edge/threshold stages. It replaces the fixed 1-2-1 Gaussian stage with:
- parametrised pixel width
- four kernel modes selected at run time and changed only on frame boundaries
- optional frame-border pass-through driven by internal row/column tracking
- fixed 3-cycle latency in every mode

## Interface
Parameters:
- DATA_W, 8: pixel width of every matrix input and of the output
- IMG_W, 1920: active pixels per line, used for border detection
- IMG_H, 1080: active lines per frame, used for border detection

Ports:
- video_clk  in  1  pixel clock; the only clock in the block
- rst_n  in  1  asynchronous, active-low reset
- cfg_mode  in  2  kernel select: 0 bypass, 1 Gaussian 3x3, 2 cross 4-neighbour, 3 horizontal 1-2-1
- cfg_border_en  in  1  1: border pixels output the unfiltered centre pixel
- matrix_de  in  1  window valid, active high
- matrix_vs  in  1  frame sync, active high; a frame starts on its rising edge
- matrix11..matrix33  in  DATA_W each  3x3 window, row-major, matrix22 is the centre
- gauss_vs  out  1  matrix_vs delayed 3 cycles
- gauss_de  out  1  matrix_de delayed 3 cycles
- gauss_data  out  DATA_W  filtered pixel; 0 whenever gauss_de is 0

## Operation
Mode latch:
- cfg_mode and cfg_border_en are sampled into act_mode and act_border on the cycle a matrix_vs rising edge is detected (vs_d==0, matrix_vs==1).
- Between those edges the active settings never change.
- Reset values: act_mode=1, act_border=0.

Kernels. Sums use width DATA_W+4 with no overflow possible:
- Mode 0: result = m22.
- Mode 1: sum = m11+2m12+m13+2m21+4m22+2m23+m31+2m32+m33; result = sum>>4.
- Mode 2: sum = 4m22+m12+m21+m23+m32; result = sum>>3.
- Mode 3: sum = m21+2m22+m23; result = sum>>2.

Position tracking:
- col counts de-high cycles within a line: cleared when de is low, incremented when de is high, saturates at IMG_W-1.
- row increments on each de falling edge, is cleared on the vs rising edge, and saturates at IMG_H-1.
- A pixel is a border pixel if col==0, col==IMG_W-1, row==0 or row==IMG_H-1.
- Lines longer than IMG_W: every pixel past the saturation point counts as border.
- Frames taller than IMG_H: every line past the saturation point counts as border.

Border and output rules:
- If act_border is 1 and the pixel is a border pixel, the result is m22 regardless of act_mode.
- If de is low on input, the stage-1 registers load 0, so gauss_data is 0 three cycles later.

## Timing
Pipeline, 3 cycles from input to output:
- Stage 1: row partial sums, delayed centre pixel, border flag.
- Stage 2: total sum and mode/border select.
- Stage 3: shift into the output register.

Latency and alignment:
- Latency is exactly 3 cycles in all modes, including bypass.
- gauss_de and gauss_vs are 3-stage shift registers, aligned with gauss_data.

Mode and reset behaviour:
- A mode change takes effect for the first pixel after the vs rising edge.
- The sync pipeline keeps running; no pixel is dropped or duplicated.
- Simultaneous vs rising edge and de high: the new mode applies to that pixel, and row is cleared before that pixel's border check.
- Reset mid-frame: all outputs go to 0 immediately, and counters, act_mode and act_border return to their reset values.
- After reset, border detection is valid from the next vs rising edge. Pixels before it use row=0, so they are treated as border if act_border is 1.

Continuous operation:
- Back-to-back de with no blanking is supported.
- Throughput is one pixel per clock.

## Configuration
- GAUSS_FILTER_ROUND_EN
  - Defined: a rounding constant of half the divisor (8, 4 or 2 for modes 1, 2, 3) is added before the shift, giving round-half-up.
  - Undefined: plain truncation.
- Bypass and border outputs are never rounded.
- Latency is unchanged either way.

## Structure
- Package gauss_pkg:
  - mode constants MODE_BYPASS=0, MODE_GAUSS=1, MODE_CROSS=2, MODE_HORIZ=3
  - typedef for the 2-bit mode
  - sum-width function DATA_W+4
- Sub-module gauss_pos_tracker, instantiated once:
  - holds the col/row counters, de/vs edge detection and the border flag
  - is registered so that it lines up with stage 1

## Test plan
- Mode 1, DATA_W=8, all nine inputs 100, border off -> gauss_data=100 exactly 3 cycles after de, with gauss_de aligned.
- Mode 1, centre 255, all others 0 -> 4*255>>4=63 (ROUND_EN undefined), or (1020+8)>>4=64 (ROUND_EN defined).
- Mode 2, m22=80, four neighbours 40, corners 255 -> (320+160)>>3=60; modes 0 and 3 on the same window give 80 and (40+160+40)>>2=60.
- cfg_mode changed from 1 to 0 mid-frame -> output stays Gaussian until the next vs rising edge, then the first pixel is bypass.
- IMG_W=8, IMG_H=4, border on, flat field with centre value 200 and neighbours 0 -> first/last column and first/last row output 200, interior outputs (4*200)>>4=50; a 10-pixel line marks pixels 8 and 9 as border.
- Assert rst_n low mid-line -> gauss_data, gauss_de and gauss_vs are 0 in the same cycle; after release, act_mode=1.

Source files
------------

// File: rtl/gauss_pkg.sv
// Shared types and helpers for the configurable 3x3 smoothing filter.
package gauss_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_GAUSS  = 2'd1,
        MODE_CROSS  = 2'd2,
        MODE_HORIZ  = 2'd3
    } mode_t;

    // Nine taps with a total weight of 16 never need more than 4 extra bits.
    function automatic int sum_w(input int data_w);
        return data_w + 4;
    endfunction

endpackage

// File: rtl/gauss_pos_tracker.sv
// Row/column position tracking and registered border flag, aligned with stage 1
// of the filter pipeline.
module gauss_pos_tracker #(
    parameter int IMG_W = 1920,
    parameter int IMG_H = 1080
) (
    input  logic video_clk,
    input  logic rst_n,
    input  logic matrix_de,
    input  logic matrix_vs,
    output logic vs_rise,
    output logic border
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [RW-1:0] row_cur;
    logic          de_d;
    logic          vs_d;
    logic          de_fall;

    assign vs_rise = matrix_vs & ~vs_d;
    assign de_fall = ~matrix_de & de_d;
    // A pixel arriving with the frame-start edge belongs to row 0 of the new frame.
    assign row_cur = vs_rise ? '0 : row_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            de_d   <= 1'b0;
            vs_d   <= 1'b0;
            border <= 1'b0;
        end else begin
            de_d <= matrix_de;
            vs_d <= matrix_vs;

            if (!matrix_de)
                col_q <= '0;
            else if (col_q != COL_LAST)
                col_q <= col_q + 1'b1;

            if (vs_rise)
                row_q <= '0;
            else if (de_fall && row_q != ROW_LAST)
                row_q <= row_q + 1'b1;

            border <= matrix_de & ((col_q == '0) | (col_q == COL_LAST) |
                                   (row_cur == '0) | (row_cur == ROW_LAST));
        end
    end

endmodule

// File: rtl/gauss_filter_cfg.sv
// Configurable 3x3 smoothing filter with a fixed 3-cycle latency.
// Define GAUSS_FILTER_ROUND_EN for round-half-up instead of truncation.
module gauss_filter_cfg
    import gauss_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 1920,
    parameter int IMG_H  = 1080
) (
    input  logic              video_clk,
    input  logic              rst_n,
    input  logic [1:0]        cfg_mode,
    input  logic              cfg_border_en,
    input  logic              matrix_de,
    input  logic              matrix_vs,
    input  logic [DATA_W-1:0] matrix11,
    input  logic [DATA_W-1:0] matrix12,
    input  logic [DATA_W-1:0] matrix13,
    input  logic [DATA_W-1:0] matrix21,
    input  logic [DATA_W-1:0] matrix22,
    input  logic [DATA_W-1:0] matrix23,
    input  logic [DATA_W-1:0] matrix31,
    input  logic [DATA_W-1:0] matrix32,
    input  logic [DATA_W-1:0] matrix33,
    output logic              gauss_vs,
    output logic              gauss_de,
    output logic [DATA_W-1:0] gauss_data
);

    localparam int SW = sum_w(DATA_W);

`ifdef GAUSS_FILTER_ROUND_EN
    localparam logic [SW-1:0] RND_GAUSS = SW'(8);
    localparam logic [SW-1:0] RND_CROSS = SW'(4);
    localparam logic [SW-1:0] RND_HORIZ = SW'(2);
`else
    localparam logic [SW-1:0] RND_GAUSS = '0;
    localparam logic [SW-1:0] RND_CROSS = '0;
    localparam logic [SW-1:0] RND_HORIZ = '0;
`endif

    function automatic logic [SW-1:0] ext(input logic [DATA_W-1:0] v);
        return SW'(v);
    endfunction

    mode_t act_mode;
    logic  act_border;
    mode_t cur_mode;
    logic  cur_border;
    logic  vs_rise;
    logic  border_s1;

    gauss_pos_tracker #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_pos (
        .video_clk (video_clk),
        .rst_n     (rst_n),
        .matrix_de (matrix_de),
        .matrix_vs (matrix_vs),
        .vs_rise   (vs_rise),
        .border    (border_s1)
    );

    // The frame-start pixel already uses the newly sampled settings.
    assign cur_mode   = vs_rise ? mode_t'(cfg_mode) : act_mode;
    assign cur_border = vs_rise ? cfg_border_en : act_border;

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            act_mode   <= MODE_GAUSS;
            act_border <= 1'b0;
        end else if (vs_rise) begin
            act_mode   <= mode_t'(cfg_mode);
            act_border <= cfg_border_en;
        end
    end

    // Stage 1: row partial sums and the 4-neighbour sum.
    logic [SW-1:0]     top_s1, mid_s1, bot_s1, nb_s1;
    logic [DATA_W-1:0] ctr_s1;
    mode_t             mode_s1;
    logic              bord_en_s1;
    logic              de_s1, vs_s1;

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            top_s1     <= '0;
            mid_s1     <= '0;
            bot_s1     <= '0;
            nb_s1      <= '0;
            ctr_s1     <= '0;
            mode_s1    <= MODE_GAUSS;
            bord_en_s1 <= 1'b0;
            de_s1      <= 1'b0;
            vs_s1      <= 1'b0;
        end else begin
            de_s1      <= matrix_de;
            vs_s1      <= matrix_vs;
            mode_s1    <= cur_mode;
            bord_en_s1 <= cur_border;
            if (matrix_de) begin
                top_s1 <= ext(matrix11) + (ext(matrix12) << 1) + ext(matrix13);
                mid_s1 <= ext(matrix21) + (ext(matrix22) << 1) + ext(matrix23);
                bot_s1 <= ext(matrix31) + (ext(matrix32) << 1) + ext(matrix33);
                nb_s1  <= ext(matrix12) + ext(matrix21) + ext(matrix23) + ext(matrix32);
                ctr_s1 <= matrix22;
            end else begin
                top_s1 <= '0;
                mid_s1 <= '0;
                bot_s1 <= '0;
                nb_s1  <= '0;
                ctr_s1 <= '0;
            end
        end
    end

    // Stage 2: kernel total (with rounding constant) and shift select.
    logic [SW-1:0] sum_nx, sum_s2;
    logic [2:0]    shift_nx, shift_s2;
    logic          de_s2, vs_s2;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        sum_nx   = ext(ctr_s1);
        shift_nx = 3'd0;
        if (!(bord_en_s1 && border_s1)) begin
            case (mode_s1)
                MODE_GAUSS: begin
                    sum_nx   = top_s1 + (mid_s1 << 1) + bot_s1 + RND_GAUSS;
                    shift_nx = 3'd4;
                end
                MODE_CROSS: begin
                    sum_nx   = (ext(ctr_s1) << 2) + nb_s1 + RND_CROSS;
                    shift_nx = 3'd3;
                end
                MODE_HORIZ: begin
                    sum_nx   = mid_s1 + RND_HORIZ;
                    shift_nx = 3'd2;
                end
                default: begin
                    sum_nx   = ext(ctr_s1);
                    shift_nx = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_s2   <= '0;
            shift_s2 <= '0;
            de_s2    <= 1'b0;
            vs_s2    <= 1'b0;
        end else begin
            sum_s2   <= sum_nx;
            shift_s2 <= shift_nx;
            de_s2    <= de_s1;
            vs_s2    <= vs_s1;
        end
    end

    // Stage 3: normalising shift into the output register.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            gauss_data <= '0;
            gauss_de   <= 1'b0;
            gauss_vs   <= 1'b0;
        end else begin
            gauss_data <= de_s2 ? DATA_W'(sum_s2 >> shift_s2) : '0;
            gauss_de   <= de_s2;
            gauss_vs   <= vs_s2;
        end
    end

endmodule

// File: tb/tb_gauss_filter_cfg.sv
// Scoreboard bench for gauss_filter_cfg: stimulus pushes expected pixels, a
// negedge monitor pops and compares them whenever gauss_de is high.
module tb_gauss_filter_cfg;

    localparam int DW = 8;
    localparam int IW = 8;
    localparam int IH = 4;
`ifdef GAUSS_FILTER_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic          video_clk = 1'b0;
    logic          rst_n;
    logic [1:0]    cfg_mode;
    logic          cfg_border_en;
    logic          matrix_de, matrix_vs;
    logic [DW-1:0] m11, m12, m13, m21, m22, m23, m31, m32, m33;
    logic          gauss_vs, gauss_de;
    logic [DW-1:0] gauss_data;

    gauss_filter_cfg #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) dut (
        .video_clk     (video_clk),
        .rst_n         (rst_n),
        .cfg_mode      (cfg_mode),
        .cfg_border_en (cfg_border_en),
        .matrix_de     (matrix_de),
        .matrix_vs     (matrix_vs),
        .matrix11      (m11),
        .matrix12      (m12),
        .matrix13      (m13),
        .matrix21      (m21),
        .matrix22      (m22),
        .matrix23      (m23),
        .matrix31      (m31),
        .matrix32      (m32),
        .matrix33      (m33),
        .gauss_vs      (gauss_vs),
        .gauss_de      (gauss_de),
        .gauss_data    (gauss_data)
    );

    always #5 video_clk = ~video_clk;

    int cyc = 0;
    always @(posedge video_clk) cyc <= cyc + 1;

    typedef struct {
        int    cyc;
        int    data;
        bit    vs;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic set_win(input int c, input int e, input int k);
        m22 = DW'(c);
        m12 = DW'(e); m21 = DW'(e); m23 = DW'(e); m32 = DW'(e);
        m11 = DW'(k); m13 = DW'(k); m31 = DW'(k); m33 = DW'(k);
    endtask

    // One pixel: centre c, 4-neighbours e, corners k, expected output exp.
    task automatic pix(input bit vs, input int c, input int e, input int k,
                       input int exp, input string tag);
        @(posedge video_clk); #1;
        matrix_de = 1'b1;
        matrix_vs = vs;
        set_win(c, e, k);
        sb.push_back('{cyc: cyc + 3, data: exp, vs: vs, tag: tag});
    endtask

    task automatic idle(input int n, input bit vs);
        repeat (n) begin
            @(posedge video_clk); #1;
            matrix_de = 1'b0;
            matrix_vs = vs;
            set_win(0, 0, 0);
        end
    endtask

    task automatic vs_pulse();
        idle(1, 1'b1);
        idle(1, 1'b0);
    endtask

    // Monitor
    always @(negedge video_clk) begin
        exp_t e;
        if (rst_n) begin
            if (gauss_de) begin
                if (sb.size() == 0) begin
                    check("unexpected_de", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check({e.tag, "_data"}, int'(gauss_data), e.data);
                    check({e.tag, "_cycle"}, cyc, e.cyc);
                    check({e.tag, "_vs"}, int'(gauss_vs), int'(e.vs));
                end
            end else begin
                check("idle_data_zero", int'(gauss_data), 0);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        cfg_mode = 2'd1;
        cfg_border_en = 1'b0;
        matrix_de = 1'b0;
        matrix_vs = 1'b0;
        set_win(0, 0, 0);
        repeat (3) @(posedge video_clk);
        #1;
        check("rst_data", int'(gauss_data), 0);
        check("rst_de", int'(gauss_de), 0);
        check("rst_vs", int'(gauss_vs), 0);
        rst_n = 1'b1;
        idle(2, 1'b0);

        // Gaussian; mode change mid-frame must not take effect yet
        vs_pulse();
        pix(0, 100, 100, 100, 100, "g_flat");
        pix(0, 255, 0, 0, RND ? 64 : 63, "g_centre");
        pix(0, 80, 40, 255, RND ? 104 : 103, "g_mixed");
        cfg_mode = 2'd0;
        pix(0, 80, 40, 255, RND ? 104 : 103, "g_hold");
        idle(3, 1'b0);

        // Bypass from the first pixel after the vs edge
        vs_pulse();
        pix(0, 80, 40, 255, 80, "byp_first");
        pix(0, 255, 0, 0, 255, "byp_centre");
        idle(3, 1'b0);

        // Cross, with vs edge and de high in the same cycle
        cfg_mode = 2'd2;
        pix(1, 80, 40, 255, 60, "cross_vs_de");
        pix(0, 100, 100, 100, 100, "cross_flat");
        idle(3, 1'b0);

        // Horizontal 1-2-1
        cfg_mode = 2'd3;
        vs_pulse();
        pix(0, 80, 40, 255, 60, "horiz_mixed");
        pix(0, 255, 0, 0, RND ? 128 : 127, "horiz_centre");
        idle(3, 1'b0);

        // Border pass-through: 5 lines (one too many), line 1 is 10 pixels long
        cfg_mode = 2'd1;
        cfg_border_en = 1'b1;
        vs_pulse();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < ((r == 1) ? 10 : 8); i++) begin
                bit b;
                b = (r == 0) || (r >= IH - 1) || (i == 0) || (i >= IW - 1);
                pix(0, 200, 0, 0, b ? 200 : 50, $sformatf("brd_r%0d_c%0d", r, i));
            end
            idle(2, 1'b0);
        end

        // Reset asserted mid-line
        cfg_mode = 2'd0;
        vs_pulse();
        for (int i = 0; i < 5; i++) pix(0, 200, 0, 0, 200, $sformatf("pre_rst_%0d", i));
        idle(1, 1'b0);
        #2;
        check("pre_rst_de", int'(gauss_de), 1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("rst_mid_data", int'(gauss_data), 0);
        check("rst_mid_de", int'(gauss_de), 0);
        check("rst_mid_vs", int'(gauss_vs), 0);
        repeat (2) @(posedge video_clk);
        #1;
        rst_n = 1'b1;
        idle(2, 1'b0);

        // No vs edge since reset: Gaussian mode and border off must be active
        cfg_mode = 2'd0;
        cfg_border_en = 1'b1;
        pix(0, 80, 40, 255, RND ? 104 : 103, "post_rst_gauss");
        pix(0, 100, 100, 100, 100, "post_rst_flat");
        idle(6, 1'b0);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
